// File: rtl/mem_b_reader_if.sv
// Memory B read port plus the valid/ready output stream of the reader.
// master = reader side, slave = memory model / consumer side.
interface mem_b_reader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_addr, mem_re, out_data, out_valid,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_addr, mem_re, out_data, out_valid,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/mem_b_reader.sv
// Walks memory B from address 0 to DEPTH-1 and streams each word out
// over valid/ready. Every output is a register or a decode of state/address.
module mem_b_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    mem_b_reader_if.master     bus,
    output logic               o_busy,
    output logic               o_done
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [DATA_W-1:0] r_data;
    logic              w_handshake;

    assign w_handshake = (r_state == S_HOLD) && bus.out_ready;

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_FETCH;
                    w_addr_next  = '0;
                end
            end
            S_FETCH: w_state_next = S_CAPT;
            S_CAPT:  w_state_next = S_HOLD;
            S_HOLD: begin
                // Increment only below the last address, so addr never wraps.
                if (w_handshake) begin
                    if (r_addr == LAST_ADDR) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_FETCH;
                        w_addr_next  = r_addr + ADDR_W'(1);
                    end
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            if (r_state == S_CAPT) begin
                r_data <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_re    = (r_state == S_FETCH);
    assign bus.out_data  = r_data;
    assign bus.out_valid = (r_state == S_HOLD);
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
endmodule

// File: tb/tb_mem_b_reader.sv
// Bench for mem_b_reader: DEPTH=8 and DEPTH=1 instances, a per-cycle timing table,
// and a word/address/cycle-count scoreboard for stalled, random and interrupted runs.
module tb_mem_b_reader;
    typedef struct {
        bit ready;
        bit exp_re;
        int exp_addr;
        bit exp_valid;
        int exp_data;
        bit exp_busy;
        bit exp_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] mem [8];
    logic [7:0] rd8, rd1;
    logic       busy8, done8, busy1, done1;

    logic       c_re, c_valid, c_busy, c_done;
    logic [2:0] c_addr;
    logic [7:0] c_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_b_reader_if #(.DATA_W(8), .ADDR_W(3)) if8 ();
    mem_b_reader_if #(.DATA_W(8), .ADDR_W(3)) if1 ();

    mem_b_reader #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start & ~sel), .bus(if8.master),
        .o_busy(busy8), .o_done(done8)
    );

    mem_b_reader #(.DATA_W(8), .ADDR_W(3), .DEPTH(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start & sel), .bus(if1.master),
        .o_busy(busy1), .o_done(done1)
    );

    // Synchronous memory B model: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (if8.mem_re) rd8 <= mem[if8.mem_addr];
        if (if1.mem_re) rd1 <= mem[if1.mem_addr];
    end

    assign if8.mem_rdata = rd8;
    assign if1.mem_rdata = rd1;
    assign if8.out_ready = ready & ~sel;
    assign if1.out_ready = ready & sel;

    assign c_re    = sel ? if1.mem_re    : if8.mem_re;
    assign c_addr  = sel ? if1.mem_addr  : if8.mem_addr;
    assign c_valid = sel ? if1.out_valid : if8.out_valid;
    assign c_data  = sel ? if1.out_data  : if8.out_data;
    assign c_busy  = sel ? busy1 : busy8;
    assign c_done  = sel ? done1 : done8;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle trace of an unstalled run, from the timing rules:
    // cycle k after the start edge is word k/3 in phase FETCH/CAPT/HOLD.
    task automatic build_table(input int depth, output vec_t tbl[$]);
        vec_t v;
        tbl = {};
        for (int k = 0; k < 3 * depth + 2; k++) begin
            v.ready     = 1'b1;
            v.exp_re    = (k < 3 * depth) && (k % 3 == 0);
            v.exp_addr  = k / 3;
            v.exp_valid = (k < 3 * depth) && (k % 3 == 2);
            v.exp_data  = (k < 3 * depth) ? int'(mem[k / 3]) : 0;
            v.exp_busy  = (k <= 3 * depth);
            v.exp_done  = (k == 3 * depth);
            tbl.push_back(v);
        end
    endtask

    task automatic run_table(input int depth);
        vec_t tbl[$];
        build_table(depth, tbl);
        start = 1'b1;
        step();
        start = 1'b0;
        foreach (tbl[i]) begin
            ready = tbl[i].ready;
            chk($sformatf("tbl%0d_re[%0d]", depth, i), 32'(c_re), 32'(tbl[i].exp_re));
            if (tbl[i].exp_re)
                chk($sformatf("tbl%0d_addr[%0d]", depth, i), 32'(c_addr), tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid[%0d]", depth, i), 32'(c_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_data[%0d]", depth, i), 32'(c_data), tbl[i].exp_data);
            chk($sformatf("tbl%0d_busy[%0d]", depth, i), 32'(c_busy), 32'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_done[%0d]", depth, i), 32'(c_done), 32'(tbl[i].exp_done));
            step();
        end
    endtask

    // One run checked against the stream rules: words in order, reads at 0..depth-1,
    // no read while a word is held, one done pulse at 3*depth + stall cycles.
    // mode 0: ready high except stall_len cycles on word stall_word; mode 1: random ready.
    task automatic run_sb(input int depth, input int mode, input int stall_word,
                          input int stall_len, input bit spam);
        int cyc = 0, words = 0, reads = 0, dones = 0, stalls = 0, held = 0;
        int done_cyc = -1;
        bit fin = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!fin && cyc < 600) begin
            if (!c_busy) begin
                fin = 1'b1;
                start = 1'b0;
            end else begin
                if (mode == 1) ready = 1'($urandom_range(0, 1));
                else if (c_valid && words == stall_word && held < stall_len) begin
                    ready = 1'b0;
                    held++;
                end else ready = 1'b1;
                if (c_re) begin
                    chk("sb_read_addr", 32'(c_addr), reads);
                    chk("sb_read_while_valid", 32'(c_valid), 0);
                    reads++;
                end
                if (c_valid) begin
                    chk("sb_word", 32'(c_data), (words < depth) ? int'(mem[words]) : -1);
                    if (ready) words++;
                    else stalls++;
                end
                if (c_done) begin
                    dones++;
                    done_cyc = cyc;
                    chk("sb_done_valid", 32'(c_valid), 0);
                end
                if (spam) start = 1'($urandom_range(0, 1));
                step();
                cyc++;
            end
        end
        ready = 1'b0;
        chk("sb_finished", 32'(fin), 1);
        chk("sb_words", words, depth);
        chk("sb_reads", reads, depth);
        chk("sb_done_pulses", dones, 1);
        chk("sb_done_cycle", done_cyc, 3 * depth + stalls);
        chk("sb_busy_len", cyc, 3 * depth + stalls + 1);
        if (mode == 0) chk("sb_stall_cycles", stalls, stall_len);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);

        // Reset held for two edges with start and ready asserted.
        rst = 1'b0;
        start = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_re", 32'(if8.mem_re), 0);
            chk("rst_addr", 32'(if8.mem_addr), 0);
            chk("rst_data", 32'(if8.out_data), 0);
            chk("rst_valid", 32'(if8.out_valid), 0);
            chk("rst_busy", 32'(busy8), 0);
            chk("rst_done", 32'(done8), 0);
            chk("rst_busy1", 32'(busy1), 0);
        end
        start = 1'b0;
        ready = 1'b0;
        rst = 1'b1;
        step();

        run_table(8);
        run_sb(8, 0, 3, 4, 1'b0);
        run_sb(8, 0, 99, 0, 1'b1);
        run_sb(8, 0, 99, 0, 1'b0);

        // Reset while word 0x15 is held.
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            if (c_valid && c_data == 8'h15) begin
                found = 1'b1;
                ready = 1'b0;
            end else step();
        end
        chk("midrst_reached", 32'(found), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_valid", 32'(c_valid), 0);
        chk("midrst_busy", 32'(c_busy), 0);
        chk("midrst_done", 32'(c_done), 0);
        chk("midrst_re", 32'(c_re), 0);
        step();
        chk("midrst_idle", 32'(c_busy), 0);
        run_sb(8, 0, 99, 0, 1'b0);

        sel = 1'b1;
        run_table(1);
        run_sb(1, 1, 0, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
            sel = 1'(r % 2);
            run_sb(sel ? 1 : 8, 1, 0, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
